// File: rtl/window_generator_pkg.sv
// window_generator_pkg: shared pixel width default and 3x3 window index layout
package window_generator_pkg;
  localparam int WG_BIT_PER_PIXEL = 8;
  localparam int WIN_TOP = 0;
  localparam int WIN_MID = 3;
  localparam int WIN_BOT = 6;
  function automatic int win_idx(input int row, input int col);
    return (row == 0 ? WIN_TOP : row == 1 ? WIN_MID : WIN_BOT) + col;
  endfunction
endpackage

// File: rtl/window_generator_line_buffer.sv
// line_buffer: one-line delay; dout is the word written depth accepts ago
module line_buffer #(
  parameter int depth = 640,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);
  logic [depth-1:0][width-1:0] mem_q;
  assign dout = mem_q[depth-1];
  // shift in a new word per accepted pixel; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (en) mem_q <= {mem_q[depth-2:0], din};
  end
endmodule

// File: rtl/window_generator.sv
// window_generator: streaming 3x3 window builder over two buffered image lines
module window_generator
  import window_generator_pkg::*;
#(
  parameter int BIT_PER_PIXEL = WG_BIT_PER_PIXEL,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [BIT_PER_PIXEL-1:0] in_pixel,
  output logic                     win_valid,
  output logic [BIT_PER_PIXEL-1:0] pixel_0,
  output logic [BIT_PER_PIXEL-1:0] pixel_1,
  output logic [BIT_PER_PIXEL-1:0] pixel_2,
  output logic [BIT_PER_PIXEL-1:0] pixel_3,
  output logic [BIT_PER_PIXEL-1:0] pixel_4,
  output logic [BIT_PER_PIXEL-1:0] pixel_5,
  output logic [BIT_PER_PIXEL-1:0] pixel_6,
  output logic [BIT_PER_PIXEL-1:0] pixel_7,
  output logic [BIT_PER_PIXEL-1:0] pixel_8,
  output logic                     frame_done,
  output logic                     sof_err
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic col_last, row_last;
  logic win_valid_q, win_valid_d, frame_done_q, frame_done_d, sof_err_q, sof_err_d;
  logic [BIT_PER_PIXEL-1:0] a_dout, b_dout;
  logic [2:0][BIT_PER_PIXEL-1:0] newest;
  logic [2:0][1:0][BIT_PER_PIXEL-1:0] hist_q, hist_d;
  logic [8:0][BIT_PER_PIXEL-1:0] pix_q, pix_d;

  line_buffer #(.depth(IMG_WIDTH), .width(BIT_PER_PIXEL)) u_lb_b (
    .clk(clk), .en(in_valid), .din(in_pixel), .dout(b_dout));
  line_buffer #(.depth(IMG_WIDTH), .width(BIT_PER_PIXEL)) u_lb_a (
    .clk(clk), .en(in_valid), .din(b_dout), .dout(a_dout));

  assign newest = {in_pixel, b_dout, a_dout};

  // position of the accepted pixel (sof forces 0,0), next counters, strobes, window update
  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_last = cur_col == CW'(IMG_WIDTH - 1);
    row_last = cur_row == RW'(IMG_HEIGHT - 1);
    col_d = !in_valid ? col_q : col_last ? '0 : cur_col + CW'(1);
    row_d = !in_valid ? row_q : !col_last ? cur_row : row_last ? '0 : cur_row + RW'(1);
    win_valid_d = in_valid && cur_row >= RW'(2) && cur_col >= CW'(2);
    frame_done_d = in_valid && col_last && row_last;
    sof_err_d = in_valid && in_sof && (col_q != '0 || row_q != '0);
    hist_d = hist_q;
    pix_d = pix_q;
    for (int r = 0; r < 3; r++) begin
      if (in_valid) hist_d[r] = {hist_q[r][0], newest[r]};
      if (win_valid_d) begin
        pix_d[win_idx(r, 0)] = hist_q[r][1];
        pix_d[win_idx(r, 1)] = hist_q[r][0];
        pix_d[win_idx(r, 2)] = newest[r];
      end
    end
  end

  // register counters, column history and outputs with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q <= 1'b0;
      hist_q <= '0;
      pix_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_valid_q <= win_valid_d;
      frame_done_q <= frame_done_d;
      sof_err_q <= sof_err_d;
      hist_q <= hist_d;
      pix_q <= pix_d;
    end
  end

  assign win_valid = win_valid_q;
  assign frame_done = frame_done_q;
  assign sof_err = sof_err_q;
  assign pixel_0 = pix_q[0];
  assign pixel_1 = pix_q[1];
  assign pixel_2 = pix_q[2];
  assign pixel_3 = pix_q[3];
  assign pixel_4 = pix_q[4];
  assign pixel_5 = pix_q[5];
  assign pixel_6 = pix_q[6];
  assign pixel_7 = pix_q[7];
  assign pixel_8 = pix_q[8];
endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator: table vectors, corner sequences and random stream against an image model
module tb_window_generator;
  localparam int W = 4;
  localparam int H = 3;
  logic clk = 0, rst_n = 0, in_valid = 0, in_sof = 0;
  logic [7:0] in_pixel = 0;
  logic win_valid, frame_done, sof_err;
  logic [7:0] pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8;
  int checks = 0, errors = 0, wcount = 0, secount = 0, fdcount = 0;
  int mr = 0, mc = 0;
  logic [7:0] img [H][W];
  logic [71:0] exp_win = 0;

  typedef struct packed {
    logic v, s;
    logic [7:0] p;
    logic wv, fd;
    logic [71:0] win;
  } vec_t;
  vec_t tbl [12];

  window_generator #(.BIT_PER_PIXEL(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .win_valid(win_valid), .pixel_0(pixel_0), .pixel_1(pixel_1), .pixel_2(pixel_2),
    .pixel_3(pixel_3), .pixel_4(pixel_4), .pixel_5(pixel_5), .pixel_6(pixel_6),
    .pixel_7(pixel_7), .pixel_8(pixel_8), .frame_done(frame_done), .sof_err(sof_err));

  always #5 clk = ~clk;

  function automatic logic [71:0] win_all();
    return {pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push(input bit v, input bit s, input logic [7:0] p);
    bit ewv = 0, efd = 0, ese = 0;
    int r, c;
    in_valid = v; in_sof = s; in_pixel = p;
    if (v) begin
      if (s) begin ese = (mr != 0 || mc != 0); mr = 0; mc = 0; end
      r = mr; c = mc;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        ewv = 1;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) exp_win = {exp_win[63:0], img[r-2+dr][c-2+dc]};
      end
      efd = (r == H - 1 && c == W - 1);
      c++;
      if (c == W) begin c = 0; r = (r + 1) % H; end
      mr = r; mc = c;
    end
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0;
    wcount += int'(win_valid);
    secount += int'(sof_err);
    fdcount += int'(frame_done);
    chk("win_valid", win_valid, ewv);
    chk("frame_done", frame_done, efd);
    chk("sof_err", sof_err, ese);
    chk("window", win_all(), exp_win);
  endtask

  task automatic frame(input int base, input bit sof, input int stall);
    for (int i = 1; i <= W * H; i++) begin
      repeat ($urandom_range(0, stall)) push(0, 0, 8'($urandom));
      push(1, sof && i == 1, 8'(base + i));
    end
  endtask

  initial begin
    for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, i == 0, 8'(i + 1), i >= 10, i == 11, 72'(0)};
    tbl[10].win = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    tbl[11].win = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_win_valid", win_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_sof_err", sof_err, 0);
    chk("reset_window", win_all(), 0);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      push(tbl[i].v, tbl[i].s, tbl[i].p);
      chk("tbl_win_valid", win_valid, tbl[i].wv);
      chk("tbl_frame_done", frame_done, tbl[i].fd);
      chk("tbl_window", win_all(), tbl[i].win);
    end
    wcount = 0; fdcount = 0;
    frame(0, 1, 3);
    chk("stall_window_count", wcount, 2);
    chk("stall_frame_done_count", fdcount, 1);
    frame(0, 1, 0);
    wcount = 0;
    frame(100, 0, 0);
    chk("b2b_window_count", wcount, 2);
    chk("b2b_second_window", win_all(), {8'd102, 8'd103, 8'd104, 8'd106, 8'd107, 8'd108, 8'd110, 8'd111, 8'd112});
    secount = 0;
    for (int i = 1; i <= 5; i++) push(1, i == 1, 8'(i));
    wcount = 0;
    frame(20, 1, 0);
    chk("sof_err_count", secount, 1);
    chk("after_sof_window_count", wcount, 2);
    for (int i = 1; i <= 10; i++) push(1, i == 1, 8'(i));
    rst_n = 0;
    #1;
    chk("async_rst_win_valid", win_valid, 0);
    chk("async_rst_frame_done", frame_done, 0);
    chk("async_rst_window", win_all(), 0);
    @(posedge clk); #2;
    rst_n = 1;
    mr = 0; mc = 0; exp_win = 0;
    wcount = 0;
    frame(50, 0, 1);
    chk("post_reset_window_count", wcount, 2);
    for (int i = 0; i < 3000; i++)
      push($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
